// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O peripherals.
// Holds the I/O window tag, the UART register offsets and the state encoding
// shared by the UART transmit and receive FSMs.
package io_pkg;

  // Upper address byte that selects the I/O window (0xFFxx).
  localparam logic [7:0] IO_HI        = 8'hFF;

  // UART register offsets within the I/O window.
  localparam logic [7:0] UART_TX_DATA = 8'h00;
  localparam logic [7:0] UART_TX_STAT = 8'h04;
  localparam logic [7:0] UART_RX_DATA = 8'h08;
  localparam logic [7:0] UART_RX_STAT = 8'h0C;

  // Serial frame phases, used by both the TX and the RX FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   rx_i         - asynchronous serial input (idle high)
//   byte_o       - last assembled byte (stable once byte_valid_o has pulsed)
//   byte_valid_o - one-cycle pulse: a frame with a good stop bit completed
//   frame_err_o  - one-cycle pulse: a frame ended with a low stop bit
module uart_rx_core
  import io_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  logic        sync1_q, sync2_q, prev_q;
  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  // NOTE: every state element is updated with non-blocking assignments so all
  // flops sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer resets to the idle line level so no false start is seen.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        // Re-check the line mid-bit; a high level means the edge was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};  // LSB arrives first
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign byte_o       = shreg_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART on the data-memory I/O bus (window 0xFFxx).
// Ports:
//   clk, rst         - system clock, synchronous active-high reset
//   io_addr/io_dout  - bus address and store data
//   io_we/io_rd      - store/load strobes (also asserted outside the window)
//   io_din           - combinational read data, 0 when not selected
//   uart_tx/uart_rx  - serial out (idle high) / asynchronous serial in
// Registers: 0x00 TX_DATA (W), 0x04 TX_STAT (R), 0x08 RX_DATA (R, clears
// RX flags), 0x0C RX_STAT (R: bit0 valid, bit1 overrun, bit2 frame error).
module io_uart
  import io_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868,
  parameter logic [7:0]  IO_HI   = io_pkg::IO_HI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [31:0] io_din,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  logic       sel;
  logic [7:0] off;
  logic       tx_ready, wr_accept, rd_clear;
  logic [7:0] rx_core_byte;
  logic       rx_core_valid, rx_core_ferr;

  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shreg_q, tx_shreg_d;
  logic        tx_q, tx_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;

  // Only the low byte of store data reaches the transmitter.
  logic unused_dout;
  assign unused_dout = ^io_dout[31:8];

  assign sel       = (io_addr[15:8] == IO_HI);
  assign off       = io_addr[7:0];
  assign tx_ready  = (tx_state_q == ST_IDLE);
  assign wr_accept = sel && io_we && (off == UART_TX_DATA) && tx_ready;
  assign rd_clear  = sel && io_rd && (off == UART_RX_DATA);

  uart_rx_core #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (uart_rx),
    .byte_o       (rx_core_byte),
    .byte_valid_o (rx_core_valid),
    .frame_err_o  (rx_core_ferr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shreg_q  <= '0;
      tx_q        <= 1'b1;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shreg_q  <= tx_shreg_d;
      tx_q        <= tx_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Transmit FSM. The serial line is registered from the next state so it
  // changes exactly on the phase boundaries and cannot glitch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (wr_accept) begin
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
          tx_shreg_d = io_dout[7:0];
        end
      end
      ST_START: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == DIV_M1) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase

    unique case (tx_state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Receive holding register. A completing frame is applied after the read
  // clear, so it wins over a same-cycle RX_DATA read; overrun looks at the
  // pre-read valid flag.
  always_comb begin
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (rd_clear) begin
      rx_valid_d  = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (rx_core_valid) begin
      rx_byte_d  = rx_core_byte;
      rx_valid_d = 1'b1;
      if (rx_valid_q) overrun_d = 1'b1;
    end
    if (rx_core_ferr) frame_err_d = 1'b1;
  end

  // Zero-latency read mux: the memory unit completes loads in the same cycle.
  always_comb begin
    io_din = '0;
    if (sel) begin
      unique case (off)
        UART_TX_STAT: io_din = {31'b0, tx_ready};
        UART_RX_DATA: io_din = {24'b0, rx_byte_q};
        UART_RX_STAT: io_din = {29'b0, frame_err_q, overrun_q, rx_valid_q};
        default:      io_din = '0;
      endcase
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart (CLK_DIV = 16). Inputs change on the falling
// edge; outputs are observed 1 time unit after the falling edge.
module tb_io_uart;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] io_addr;
  logic [31:0] io_dout;
  logic        io_we, io_rd;
  logic [31:0] io_din;
  logic        uart_tx, uart_rx;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state of the receive registers, updated per frame and per read.
  logic [7:0] m_byte;
  logic       m_valid, m_over, m_ferr;

  always #5 clk = ~clk;

  io_uart #(.CLK_DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_we   (io_we),
    .io_rd   (io_rd),
    .io_din  (io_din),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected line level i cycles into an 8N1 frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    int j;
    j = i / DIV;
    if (j == 0)      return 1'b0;
    else if (j <= 8) return d[j-1];
    else             return 1'b1;
  endfunction

  function automatic logic [31:0] m_stat();
    return {29'b0, m_ferr, m_over, m_valid};
  endfunction

  // Combinational look at a register without a load strobe.
  task automatic peek(input logic [15:0] a, output logic [31:0] d);
    io_addr = a;
    io_rd   = 1'b0;
    #1 d = io_din;
  endtask

  // One-cycle load with io_rd asserted; returns the same-cycle data.
  task automatic read_reg(input logic [15:0] a, output logic [31:0] d);
    io_addr = a;
    io_rd   = 1'b1;
    #1 d = io_din;
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we   = 1'b1;
    @(negedge clk);
    io_we   = 1'b0;
  endtask

  // Write d to TX_DATA and follow the whole frame cycle by cycle. If drop_at
  // is non-negative, a second write of 0x3C is attempted at that cycle.
  task automatic tx_frame(input logic [7:0] d, input int drop_at);
    logic [31:0] r;
    write_reg(16'hFF00, {24'hABCDEF, d});
    for (int i = 0; i <= 10 * DIV; i++) begin
      io_we = 1'b0;
      peek(16'hFF04, r);
      check($sformatf("tx_line[%0d]", i), {31'b0, uart_tx},
            {31'b0, (i < 10 * DIV) ? frame_bit(d, i) : 1'b1});
      check($sformatf("tx_stat[%0d]", i), r, (i < 10 * DIV) ? 32'd0 : 32'd1);
      if (i == drop_at) begin
        io_addr = 16'hFF00;
        io_dout = 32'h0000003C;
        io_we   = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  // Drive one frame onto uart_rx, leave the line idle, update the model.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    if (stop) begin
      if (m_valid) m_over = 1'b1;
      m_valid = 1'b1;
      m_byte  = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] r;
    peek(16'hFF0C, r);
    check({tag, "_stat"}, r, m_stat());
    peek(16'hFF08, r);
    check({tag, "_data"}, r, {24'b0, m_byte});
  endtask

  task automatic consume_rx(input string tag);
    logic [31:0] r;
    read_reg(16'hFF08, r);
    check({tag, "_read"}, r, {24'b0, m_byte});
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_ferr  = 1'b0;
    peek(16'hFF0C, r);
    check({tag, "_stat_after"}, r, m_stat());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    logic        s;
    rst = 1'b1; io_addr = '0; io_dout = '0; io_we = 1'b0; io_rd = 1'b0; uart_rx = 1'b1;
    m_byte = '0; m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    peek(16'hFF04, r); check("rst_tx_stat", r, 32'd1);
    peek(16'hFF0C, r); check("rst_rx_stat", r, 32'd0);
    peek(16'hFF08, r); check("rst_rx_data", r, 32'd0);
    check("rst_tx_line", {31'b0, uart_tx}, 32'd1);

    // Transmit 0xA5 with a dropped write 5 cycles after the accepted one.
    tx_frame(8'hA5, 4);
    repeat (3) @(negedge clk);
    check("tx_no_second_frame", {31'b0, uart_tx}, 32'd1);

    // A few random transmit bytes.
    for (int n = 0; n < 3; n++) begin
      tx_frame(8'($urandom), -1);
      repeat (2) @(negedge clk);
    end

    // Non-I/O store and an undecoded offset must not start a frame.
    write_reg(16'h0F00, 32'h0000FF00);
    write_reg(16'hFF10, 32'h00000055);
    for (int i = 0; i < 20; i++) begin
      #1 check("nonio_tx_line", {31'b0, uart_tx}, 32'd1);
      @(negedge clk);
    end
    peek(16'hFF04, r); check("nonio_tx_stat", r, 32'd1);
    peek(16'hFF10, r); check("undecoded_read", r, 32'd0);
    peek(16'hFF00, r); check("tx_data_read", r, 32'd0);
    peek(16'h0F0C, r); check("unselected_read", r, 32'd0);

    // Receive: single frame, then consume it.
    send_rx(8'h5A, 1'b1);
    check_rx("rx_5a");
    consume_rx("rx_5a");

    // Two frames without a read: overrun, latest byte kept.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    check_rx("rx_overrun");
    consume_rx("rx_overrun");

    // Bad stop bit: frame error, byte discarded.
    send_rx(8'hC3, 1'b0);
    check_rx("rx_ferr");

    // Short low glitch: no state change.
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check_rx("rx_glitch");
    consume_rx("rx_ferr");

    // Random receive traffic against the model.
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_rx(b, s);
      check_rx($sformatf("rx_rand%0d", n));
      if ($urandom_range(0, 1) == 1) consume_rx($sformatf("rx_rand%0d", n));
    end

    // Reset in the middle of a transmit frame.
    write_reg(16'hFF00, 32'h00000055);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 check("rst_mid_tx_line", {31'b0, uart_tx}, 32'd1);
    peek(16'hFF04, r); check("rst_mid_tx_stat", r, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    m_byte = '0; m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0;
    check_rx("rst_mid_rx");
    repeat (2 * DIV) @(negedge clk);
    #1 check("post_rst_tx_idle", {31'b0, uart_tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/io_uart.md
Name: io_uart

Overview:
Memory-mapped UART peripheral on the data-memory unit's I/O bus. It decodes the 0xFFxx I/O window, accepts byte writes to transmit serially (8N1), and receives 8N1 frames into a holding register. Readable status and data are returned on io_din, which the memory unit muxes onto the load path. It is the first downstream consumer of the I/O bus in the CPU top level.

Parameters:
CLK_DIV, 868, clk cycles per serial bit (100 MHz / 115200); legal range 16..65535.
IO_HI, 8'hFF, required value of io_addr[15:8] for any register access.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
io_addr  input  16  I/O address from memory unit
io_dout  input  32  store data from memory unit
io_we  input  1  store strobe; also asserted for non-I/O stores, so address must be decoded
io_rd  input  1  load strobe; also asserted for non-I/O loads
io_din  output  32  read data to memory unit
uart_tx  output  1  serial out, idle high
uart_rx  input  1  serial in, asynchronous

Behaviour:
- sel = (io_addr[15:8] == IO_HI). Register offset = io_addr[7:0]. Only offsets 0x00, 0x04, 0x08, 0x0C are decoded; others read 0, and writes to them are ignored.
- 0x00 TX_DATA (W): if sel && io_we && tx_ready, latch io_dout[7:0] and start a frame on the next edge. A write while busy is dropped, with no error flag. Reads return 0.
- 0x04 TX_STAT (R): bit0 = tx_ready; bits[31:1] = 0.
- 0x08 RX_DATA (R): {24'b0, rx_byte}. When sel && io_rd at this offset, rx_valid and overrun clear on that edge; the returned data is unchanged.
- 0x0C RX_STAT (R): bit0 = rx_valid, bit1 = overrun, bit2 = frame_err (sticky; cleared by an RX_DATA read).
- io_din is combinational from io_addr and current state, with zero latency: the data memory reads asynchronously and the load completes in the same cycle. When !sel, io_din = 0.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on an accepted write.
  - Each state lasts CLK_DIV cycles, using a bit counter 0..CLK_DIV-1.
  - DATA shifts out LSB first for 8 bits; STOP drives 1, then returns to IDLE.
  - tx_ready = (state == IDLE). It deasserts the cycle after the accepted write.
  - A write on the same cycle the STOP state ends is dropped, because tx_ready is still 0.
- RX path: two-flop synchronizer on uart_rx.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized falling edge goes to START.
  - START: after CLK_DIV/2 cycles, resample. If the line is high, treat it as a glitch and return to IDLE; otherwise go to DATA.
  - DATA: sample every CLK_DIV cycles, 8 bits, LSB first.
  - STOP: sample after CLK_DIV cycles. If the sample is 1, rx_byte ← shift register and rx_valid ← 1; if rx_valid was already 1, overrun ← 1 and rx_byte is overwritten. If the sample is 0, frame_err ← 1 and the byte is discarded. Return to IDLE.
- Simultaneous RX completion and RX_DATA read in the same cycle: completion wins. rx_valid = 1 and the new byte is stored; overrun is set only if rx_valid was 1 before the read.
- Reset values: uart_tx = 1, both FSMs IDLE, counters 0, rx_byte = 0, rx_valid/overrun/frame_err = 0. tx_ready = 1 from the first cycle after reset.
- Reset mid-frame aborts immediately: uart_tx = 1 on the next edge, and any partial RX byte is discarded.
- io_we and io_rd asserted together at a decoded offset: both act independently.

Decomposition:
- Shared package io_pkg holds:
  - IO_HI
  - register offsets UART_TX_DATA = 8'h00, UART_TX_STAT = 8'h04, UART_RX_DATA = 8'h08, UART_RX_STAT = 8'h0C
  - the 2-bit FSM state encodings
- Natural sub-module: uart_rx_core (synchronizer, RX FSM, shift register, byte_valid/frame_err pulse outputs). The TX FSM and register decode stay in io_uart.

Test Plan:
- Reset, then read 0xFF04 and 0xFF0C → io_din = 1 and 0; uart_tx = 1.
- Use CLK_DIV = 16 for all scenarios.
  - Write 0xFF00 = 0x000000A5 → uart_tx = 0 for 16 cycles, then 1,0,1,0,0,1,0,1 (16 cycles each), then 1. TX_STAT reads 0 during the frame and 1 after 160 cycles.
  - Second write of 0x3C issued 5 cycles after the first → dropped; only the 0xA5 frame appears.
- Drive an RX frame of 0x5A → RX_STAT = 1 and RX_DATA = 0x0000005A. Reading RX_DATA returns 0x5A; the next RX_STAT read = 0.
- Two RX frames (0x11, 0x22) with no read in between → RX_STAT = 3 and RX_DATA = 0x22; after the read, RX_STAT = 0.
- RX frame with stop bit = 0 → RX_STAT bit2 = 1 and rx_valid = 0. A 3-cycle low glitch on uart_rx → no state change.
- Write 0x0000FF00 with io_addr = 0x0F00 (non-I/O) → no TX activity. Read 0xFF10 → 0. Assert rst mid-TX → uart_tx = 1 on the next edge and TX_STAT = 1.
